// File: rtl/cpu_step_ctrl_pkg.sv
// cpu_step_ctrl_pkg
//   Shared definitions for the CPU run-control sequencer: run-state
//   encoding (visible on the State port), slow-tick counter width and
//   button bit assignments.
package cpu_step_ctrl_pkg;

   // Encoding is externally visible on State: RUN=0, HALT=1, STEP=2.
   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HALT = 2'd1,
      ST_STEP = 2'd2
   } run_state_e;

   localparam int unsigned TICK_W = 28;

   localparam int unsigned BTN_RUN  = 0;
   localparam int unsigned BTN_STEP = 1;
   localparam int unsigned BTN_ARM  = 2;

endpackage

// File: rtl/cpu_step_ctrl_debouncer.sv
// Debouncer
//   Conditions one asynchronous push button: 2-FF synchroniser, counter
//   debouncer, then rising-edge detect.
// Ports:
//   Clock  in   system clock
//   Reset  in   synchronous, active-high reset
//   In     in   raw asynchronous button level
//   Level  out  debounced level
//   Press  out  one-cycle pulse on each debounced rising edge
module Debouncer #(
   parameter int unsigned DEBOUNCE_MAX = 250000
) (
   input  logic Clock,
   input  logic Reset,
   input  logic In,
   output logic Level,
   output logic Press
);

   localparam int unsigned CNT_W = (DEBOUNCE_MAX > 2) ? $clog2(DEBOUNCE_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MAX - 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             prev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The counter only runs while the synchronised input disagrees with the
   // debounced level; the DEBOUNCE_MAX-th consecutive disagreeing cycle
   // commits the new level and restarts the count.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         prev_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= In;
         sync2_q <= sync1_q;
         level_q <= level_d;
         prev_q  <= level_q;
         cnt_q   <= cnt_d;
      end
   end

   assign Level = level_q;
   assign Press = level_q & ~prev_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl
//   Run-control sequencer for the CPU instruction cycle. Produces the
//   one-cycle Go strobe that advances the CPU, with free-run (slow tick),
//   turbo, halt, single-step and breakpoint-halt modes.
// Ports:
//   Clock    in   system clock
//   Reset    in   synchronous, active-high reset
//   Turbo    in   async switch; Go every cycle while running
//   Btns     in   async buttons: [0] run/stop, [1] step, [2] breakpoint arm
//   IP       in   current CPU instruction pointer
//   BrkAddr  in   breakpoint address
//   Go       out  one-cycle execute strobe
//   State    out  RUN=0, HALT=1, STEP=2
//   Armed    out  breakpoint enabled
//   BrkHit   out  HALT was entered by the breakpoint
module cpu_step_ctrl
   import cpu_step_ctrl_pkg::*;
#(
   parameter int unsigned TICK_MAX     = 12500000,
   parameter int unsigned DEBOUNCE_MAX = 250000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Turbo,
   input  logic [2:0] Btns,
   input  logic [7:0] IP,
   input  logic [7:0] BrkAddr,
   output logic       Go,
   output logic [1:0] State,
   output logic       Armed,
   output logic       BrkHit
);

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_MAX);

   logic [2:0]        press;
   logic [2:0]        btn_level_unused;  // debounced levels, kept for probing only
   logic              turbo_s1_q, turbo_s_q;
   logic [TICK_W-1:0] cnt_q, cnt_d;
   run_state_e        state_q, state_d;
   logic              armed_q, armed_d;
   logic              brk_hit_q, brk_hit_d;
   logic              skip_q, skip_d;
   logic              hit;
   logic              go_run;

   Debouncer #(.DEBOUNCE_MAX(DEBOUNCE_MAX)) u_db_run (
      .Clock (Clock),
      .Reset (Reset),
      .In    (Btns[BTN_RUN]),
      .Level (btn_level_unused[BTN_RUN]),
      .Press (press[BTN_RUN])
   );

   Debouncer #(.DEBOUNCE_MAX(DEBOUNCE_MAX)) u_db_step (
      .Clock (Clock),
      .Reset (Reset),
      .In    (Btns[BTN_STEP]),
      .Level (btn_level_unused[BTN_STEP]),
      .Press (press[BTN_STEP])
   );

   Debouncer #(.DEBOUNCE_MAX(DEBOUNCE_MAX)) u_db_arm (
      .Clock (Clock),
      .Reset (Reset),
      .In    (Btns[BTN_ARM]),
      .Level (btn_level_unused[BTN_ARM]),
      .Press (press[BTN_ARM])
   );

   assign cnt_d = (cnt_q == TICK_LAST) ? '0 : cnt_q + TICK_W'(1);

   // skip masks the breakpoint for the instruction we resume on, so leaving
   // a breakpoint halt executes BrkAddr once instead of re-halting.
   assign hit = (state_q == ST_RUN) & armed_q & (IP == BrkAddr) & ~skip_q;

   assign go_run = ((cnt_q == '0) | turbo_s_q) & ~hit;

   always_comb begin
      state_d   = state_q;
      brk_hit_d = brk_hit_q;
      armed_d   = armed_q ^ press[BTN_ARM];
      unique case (state_q)
         ST_RUN: begin
            if (hit) begin
               state_d   = ST_HALT;
               brk_hit_d = 1'b1;
            end else if (press[BTN_RUN]) begin
               state_d = ST_HALT;
            end
         end
         ST_HALT: begin
            if (press[BTN_RUN]) begin
               state_d   = ST_RUN;
               brk_hit_d = 1'b0;
            end else if (press[BTN_STEP]) begin
               state_d = ST_STEP;
            end
         end
         ST_STEP: state_d = ST_HALT;
         default: state_d = ST_RUN;
      endcase

      // Setting on HALT exit takes priority over the clear.
      skip_d = skip_q;
      if (IP != BrkAddr) begin
         skip_d = 1'b0;
      end
      if ((state_q == ST_HALT) && (state_d != ST_HALT)) begin
         skip_d = 1'b1;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         turbo_s1_q <= 1'b0;
         turbo_s_q  <= 1'b0;
         cnt_q      <= '0;
         state_q    <= ST_RUN;
         armed_q    <= 1'b0;
         brk_hit_q  <= 1'b0;
         skip_q     <= 1'b0;
      end else begin
         turbo_s1_q <= Turbo;
         turbo_s_q  <= turbo_s1_q;
         cnt_q      <= cnt_d;
         state_q    <= state_d;
         armed_q    <= armed_d;
         brk_hit_q  <= brk_hit_d;
         skip_q     <= skip_d;
      end
   end

   always_comb begin
      Go = 1'b0;
      if (!Reset) begin
         unique case (state_q)
            ST_RUN:  Go = go_run;
            ST_STEP: Go = 1'b1;
            default: Go = 1'b0;
         endcase
      end
   end

   assign State  = state_q;
   assign Armed  = armed_q;
   assign BrkHit = brk_hit_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
module tb_cpu_step_ctrl;

   localparam int unsigned TM = 9;
   localparam int unsigned DM = 4;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       Turbo = 1'b0;
   logic [2:0] Btns = 3'b000;
   logic [7:0] IP = 8'd0;
   logic [7:0] BrkAddr = 8'd200;
   logic       Go;
   logic [1:0] State;
   logic       Armed;
   logic       BrkHit;

   always #5 Clock = ~Clock;

   cpu_step_ctrl #(.TICK_MAX(TM), .DEBOUNCE_MAX(DM)) dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .Turbo   (Turbo),
      .Btns    (Btns),
      .IP      (IP),
      .BrkAddr (BrkAddr),
      .Go      (Go),
      .State   (State),
      .Armed   (Armed),
      .BrkHit  (BrkHit)
   );

   int total = 0;
   int bad = 0;

   // Reference model: state as 0/1/2, cycles since reset for the slow tick,
   // per-button delay line and a window of the last DM synchronised samples.
   int          m_st = 0;
   bit          m_armed, m_bh, m_skip, m_valid;
   int unsigned m_csr = 0;
   bit          m_s1 [3];
   bit          m_s2 [3];
   bit          m_lvl[3];
   bit          m_plv[3];
   bit          m_hist[3][DM];
   int          m_n[3];
   bit          m_t1, m_t2;
   logic [7:0]  ip_m = 8'd0;

   function automatic bit m_hit();
      return (m_st == 0) && m_armed && (IP == BrkAddr) && !m_skip;
   endfunction

   function automatic bit m_go();
      if (Reset) return 1'b0;
      if (m_st == 2) return 1'b1;
      if (m_st == 0) return (((m_csr % (TM + 1)) == 0) || m_t2) && !m_hit();
      return 1'b0;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic settle();
      #1;
      chk("go", {7'd0, Go}, {7'd0, m_go()});
      if (m_valid) begin
         chk("state", {6'd0, State}, 8'(m_st));
         chk("armed", {7'd0, Armed}, {7'd0, m_armed});
         chk("brkhit", {7'd0, BrkHit}, {7'd0, m_bh});
      end
   endtask

   task automatic model_step();
      bit p[3];
      bit h, g, all_diff;
      int nst;
      if (Reset) begin
         m_st = 0; m_armed = 0; m_bh = 0; m_skip = 0; m_csr = 0; m_valid = 1;
         m_t1 = 0; m_t2 = 0;
         for (int b = 0; b < 3; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_plv[b] = 0; m_n[b] = 0;
         end
      end else begin
         for (int b = 0; b < 3; b++) p[b] = m_lvl[b] && !m_plv[b];
         h = m_hit();
         g = m_go();
         if (g) ip_m = ip_m + 8'd1;
         nst = m_st;
         if (m_st == 0) begin
            if (h) begin nst = 1; m_bh = 1; end
            else if (p[0]) nst = 1;
         end else if (m_st == 1) begin
            if (p[0]) begin nst = 0; m_bh = 0; end
            else if (p[1]) nst = 2;
         end else begin
            nst = 1;
         end
         if (IP != BrkAddr) m_skip = 0;
         if (m_st == 1 && nst != 1) m_skip = 1;
         m_st = nst;
         if (p[2]) m_armed = !m_armed;
         for (int b = 0; b < 3; b++) begin
            for (int k = DM - 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
            m_hist[b][0] = m_s2[b];
            if (m_n[b] < DM) m_n[b]++;
            m_plv[b] = m_lvl[b];
            all_diff = (m_n[b] == DM);
            for (int k = 0; k < DM; k++) if (m_hist[b][k] == m_lvl[b]) all_diff = 0;
            if (all_diff) begin
               m_lvl[b] = !m_lvl[b];
               m_n[b] = 0;
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = Btns[b];
         end
         m_t2 = m_t1;
         m_t1 = Turbo;
         m_csr++;
      end
   endtask

   task automatic advance();
      model_step();
      @(negedge Clock);
      IP = ip_m;
   endtask

   task automatic tick();
      settle();
      advance();
   endtask

   int gos;
   int left[3];

   initial begin
      // Reset, then slow-tick Go pattern.
      repeat (3) tick();
      Reset = 1'b0;
      for (int i = 0; i < 25; i++) begin
         settle();
         chk("tick_go_lit", {7'd0, Go}, (i % 10 == 0) ? 8'd1 : 8'd0);
         if (i == 0) chk("reset_state_lit", {6'd0, State}, 8'd0);
         advance();
      end

      // Turbo on: Go every cycle from two cycles after the raise.
      Turbo = 1'b1;
      for (int i = 0; i < 8; i++) begin
         settle();
         if (i >= 2) chk("turbo_go_lit", {7'd0, Go}, 8'd1);
         advance();
      end
      Turbo = 1'b0;
      repeat (15) tick();

      // Short glitch: no state change.
      for (int i = 0; i < 12; i++) begin
         Btns = (i < 3) ? 3'b001 : 3'b000;
         settle();
         chk("glitch_state_lit", {6'd0, State}, 8'd0);
         advance();
      end

      // Held run press: pulse at +6, HALT at +7.
      for (int i = 0; i < 12; i++) begin
         Btns = (i < 10) ? 3'b001 : 3'b000;
         settle();
         if (i == 7) chk("halt_state_lit", {6'd0, State}, 8'd1);
         if (i >= 7) chk("halt_go_lit", {7'd0, Go}, 8'd0);
         advance();
      end

      // Single step from HALT.
      gos = 0;
      for (int i = 0; i < 12; i++) begin
         Btns = (i < 8) ? 3'b010 : 3'b000;
         settle();
         if (i == 7) begin
            chk("step_state_lit", {6'd0, State}, 8'd2);
            chk("step_go_lit", {7'd0, Go}, 8'd1);
         end
         if (i == 8) chk("step_back_lit", {6'd0, State}, 8'd1);
         gos += int'(Go);
         advance();
      end
      chk("step_go_count_lit", 8'(gos), 8'd1);

      // Run and step together: run wins.
      for (int i = 0; i < 12; i++) begin
         Btns = (i < 8) ? 3'b011 : 3'b000;
         settle();
         if (i == 7) chk("run_wins_lit", {6'd0, State}, 8'd0);
         advance();
      end

      // Arm the breakpoint.
      for (int i = 0; i < 10; i++) begin
         Btns = (i < 8) ? 3'b100 : 3'b000;
         settle();
         if (i == 7) chk("armed_lit", {7'd0, Armed}, 8'd1);
         advance();
      end
      Turbo = 1'b1;
      repeat (4) tick();
      BrkAddr = 8'd5;
      ip_m = 8'd2;
      IP = 8'd2;
      for (int i = 0; i < 6; i++) begin
         settle();
         if (i < 3) chk("bp_run_go_lit", {7'd0, Go}, 8'd1);
         if (i == 3) begin
            chk("bp_ip_lit", IP, 8'd5);
            chk("bp_go_suppressed_lit", {7'd0, Go}, 8'd0);
         end
         if (i == 4) begin
            chk("bp_state_lit", {6'd0, State}, 8'd1);
            chk("bp_brkhit_lit", {7'd0, BrkHit}, 8'd1);
         end
         advance();
      end

      // Resume: BrkAddr executes once without re-halting.
      for (int i = 0; i < 12; i++) begin
         Btns = (i < 8) ? 3'b001 : 3'b000;
         settle();
         if (i == 7) begin
            chk("resume_go_lit", {7'd0, Go}, 8'd1);
            chk("resume_ip_lit", IP, 8'd5);
         end
         if (i == 8) begin
            chk("resume_state_lit", {6'd0, State}, 8'd0);
            chk("resume_ip_next_lit", IP, 8'd6);
            chk("resume_brkhit_lit", {7'd0, BrkHit}, 8'd0);
         end
         advance();
      end
      repeat (5) tick();
      ip_m = 8'd3;
      IP = 8'd3;
      for (int i = 0; i < 5; i++) begin
         settle();
         if (i == 2) chk("rehit_go_lit", {7'd0, Go}, 8'd0);
         if (i == 3) begin
            chk("rehit_state_lit", {6'd0, State}, 8'd1);
            chk("rehit_brkhit_lit", {7'd0, BrkHit}, 8'd1);
         end
         advance();
      end

      // Reset while HALT/armed with a run press mid-debounce.
      for (int i = 0; i < 16; i++) begin
         Btns = (i < 2) ? 3'b001 : 3'b000;
         Reset = (i == 2);
         settle();
         if (i == 2) chk("reset_go_lit", {7'd0, Go}, 8'd0);
         if (i == 3) begin
            chk("rst_armed_lit", {7'd0, Armed}, 8'd0);
            chk("rst_brkhit_lit", {7'd0, BrkHit}, 8'd0);
         end
         if (i >= 3) chk("rst_state_lit", {6'd0, State}, 8'd0);
         advance();
      end
      Reset = 1'b0;

      // Randomised run against the model.
      for (int b = 0; b < 3; b++) left[b] = 0;
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < 3; b++) begin
            if (left[b] == 0) begin
               Btns[b] = ($urandom_range(0, 3) == 0);
               left[b] = int'($urandom_range(1, 12));
            end
            left[b]--;
         end
         if ($urandom_range(0, 49) == 0) Turbo = ~Turbo;
         if (i % 64 == 0) BrkAddr = ip_m + 8'($urandom_range(1, 30));
         Reset = ($urandom_range(0, 699) == 0);
         tick();
      end
      Reset = 1'b0;
      Btns = 3'b000;
      repeat (4) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
